// File: rtl/mips_pkg.sv
// Shared constants and pipeline payload types for the MIPS front end.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] PC_RESET  = 32'h0000_3000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
    localparam logic [XLEN-1:0] LINK_OFS  = 32'd8;

    // F/D payload
    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc8;
    } fd_t;

    // D/E payload; all-zero is a nop bubble
    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] pc8;
        logic [XLEN-1:0] rs_val;
        logic [XLEN-1:0] rt_val;
        logic [XLEN-1:0] ext;
    } de_t;

endpackage

// File: rtl/pipe_front_regs_if.sv
// Front-end pipeline register bus.
//   slave  : the register block (takes stall/redirect/D values, drives PC and pipeline regs)
//   master : the surrounding core (hazard unit, IM, D-stage datapath)
interface pipe_front_regs_if
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) ();

    logic                delay;
    logic                npc_sel_d;
    logic [XLEN-1:0]     npc_d;
    logic [XLEN-1:0]     instr_f;
    logic [XLEN-1:0]     pc_f;
    logic [XLEN-1:0]     ir_d;
    logic [XLEN-1:0]     pc_d;
    logic [XLEN-1:0]     pc8_d;
    logic [XLEN-1:0]     rs_val_d;
    logic [XLEN-1:0]     rt_val_d;
    logic [XLEN-1:0]     ext_d;
    logic [XLEN-1:0]     ir_e;
    logic [XLEN-1:0]     pc8_e;
    logic [XLEN-1:0]     rs_val_e;
    logic [XLEN-1:0]     rt_val_e;
    logic [XLEN-1:0]     ext_e;
    logic [CNT_W-1:0]    stall_cnt;

    modport slave (
        input  delay, npc_sel_d, npc_d, instr_f, rs_val_d, rt_val_d, ext_d,
        output pc_f, ir_d, pc_d, pc8_d, ir_e, pc8_e, rs_val_e, rt_val_e, ext_e, stall_cnt
    );

    modport master (
        output delay, npc_sel_d, npc_d, instr_f, rs_val_d, rt_val_d, ext_d,
        input  pc_f, ir_d, pc_d, pc8_d, ir_e, pc8_e, rs_val_e, rt_val_e, ext_e, stall_cnt
    );

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register: synchronous clear (priority) then load-enable.
//   clk   : clock
//   i_en  : load i_d when 1, hold when 0
//   i_clr : synchronous zero, overrides i_en
//   i_d   : next value
//   o_q   : registered value
module pipe_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_front_regs.sv
// PC register, F/D and D/E pipeline registers and stall-cycle counter.
//   clk, reset : clock and synchronous active-high reset
//   bus        : stall/redirect/D-stage inputs, PC and pipeline register outputs
module pipe_front_regs #(
    parameter logic [31:0] PC_RESET = mips_pkg::PC_RESET,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_front_regs_if.slave  bus
);
    import mips_pkg::*;

    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_stall_cnt;
    fd_t              w_fd_d;
    fd_t              w_fd_q;
    de_t              w_de_d;
    de_t              w_de_q;

    // PC: stall holds, redirect only when not stalled, else sequential
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_RESET;
        end else if (!bus.delay) begin
            if (bus.npc_sel_d) begin
                r_pc <= bus.npc_d;
            end else begin
                r_pc <= r_pc + PC_STEP;
            end
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (bus.delay && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // F/D: no flush on redirect, the fetched instruction is the delay slot
    always_comb begin
        w_fd_d     = '0;
        w_fd_d.ir  = bus.instr_f;
        w_fd_d.pc  = r_pc;
        w_fd_d.pc8 = r_pc + LINK_OFS;
    end

    pipe_reg #(.W($bits(fd_t))) u_fd (
        .clk   (clk),
        .i_en  (!bus.delay),
        .i_clr (reset),
        .i_d   (w_fd_d),
        .o_q   (w_fd_q)
    );

    // D/E: a stall loads the all-zero bubble
    always_comb begin
        w_de_d        = '0;
        w_de_d.ir     = w_fd_q.ir;
        w_de_d.pc8    = w_fd_q.pc8;
        w_de_d.rs_val = bus.rs_val_d;
        w_de_d.rt_val = bus.rt_val_d;
        w_de_d.ext    = bus.ext_d;
    end

    pipe_reg #(.W($bits(de_t))) u_de (
        .clk   (clk),
        .i_en  (1'b1),
        .i_clr (reset | bus.delay),
        .i_d   (w_de_d),
        .o_q   (w_de_q)
    );

    assign bus.pc_f      = r_pc;
    assign bus.ir_d      = w_fd_q.ir;
    assign bus.pc_d      = w_fd_q.pc;
    assign bus.pc8_d     = w_fd_q.pc8;
    assign bus.ir_e      = w_de_q.ir;
    assign bus.pc8_e     = w_de_q.pc8;
    assign bus.rs_val_e  = w_de_q.rs_val;
    assign bus.rt_val_e  = w_de_q.rt_val;
    assign bus.ext_e     = w_de_q.ext;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Bench for pipe_front_regs: directed stimulus, pipeline-slot model, per-cycle compare.
module tb_pipe_front_regs;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_front_regs_if #(.CNT_W(16)) bus ();
    pipe_front_regs_if #(.CNT_W(2))  bus2 ();

    pipe_front_regs #(.PC_RESET(32'h0000_3000), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    pipe_front_regs #(.PC_RESET(32'h0000_3000), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (rst),
        .bus   (bus2)
    );

    function automatic logic [31:0] im(input logic [31:0] a);
        return 32'h8C00_0000 + a;
    endfunction

    assign bus.instr_f    = im(bus.pc_f);
    assign bus2.instr_f   = im(bus2.pc_f);
    assign bus2.delay     = bus.delay;
    assign bus2.npc_sel_d = bus.npc_sel_d;
    assign bus2.npc_d     = bus.npc_d;
    assign bus2.rs_val_d  = bus.rs_val_d;
    assign bus2.rt_val_d  = bus.rt_val_d;
    assign bus2.ext_d     = bus.ext_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Model: pipeline slots plus an unbounded stall tally
    typedef struct { logic [31:0] ir, pc, pc8; } m_fd_t;
    typedef struct { logic [31:0] ir, pc8, rs, rt, ext; } m_de_t;

    logic [31:0] m_pc;
    m_fd_t       m_fd;
    m_de_t       m_de;
    int          m_stalls;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc     = 32'h0000_3000;
            m_fd     = '{0, 0, 0};
            m_de     = '{0, 0, 0, 0, 0};
            m_stalls = 0;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            if (bus.delay) begin
                m_de = '{0, 0, 0, 0, 0};
                m_stalls++;
            end else begin
                m_de = '{m_fd.ir, m_fd.pc8, bus.rs_val_d, bus.rt_val_d, bus.ext_d};
                m_fd = '{im(m_pc), m_pc, m_pc + 32'd8};
                m_pc = bus.npc_sel_d ? bus.npc_d : m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("pc_f",      bus.pc_f,     m_pc);
            check("ir_d",      bus.ir_d,     m_fd.ir);
            check("pc_d",      bus.pc_d,     m_fd.pc);
            check("pc8_d",     bus.pc8_d,    m_fd.pc8);
            check("ir_e",      bus.ir_e,     m_de.ir);
            check("pc8_e",     bus.pc8_e,    m_de.pc8);
            check("rs_val_e",  bus.rs_val_e, m_de.rs);
            check("rt_val_e",  bus.rt_val_e, m_de.rt);
            check("ext_e",     bus.ext_e,    m_de.ext);
            check("stall_cnt", 32'(bus.stall_cnt), (m_stalls > 65535) ? 32'd65535 : 32'(m_stalls));
            check("stall_cnt_sat", 32'(bus2.stall_cnt), (m_stalls > 3) ? 32'd3 : 32'(m_stalls));
        end
    end

    task automatic step(input logic d, input logic s, input logic [31:0] t);
        bus.delay     = d;
        bus.npc_sel_d = s;
        bus.npc_d     = t;
        bus.rs_val_d  = $urandom;
        bus.rt_val_d  = $urandom;
        bus.ext_d     = $urandom;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("L_rst_pc", bus.pc_f, 32'h0000_3000);
        check("L_rst_ird", bus.ir_d, 32'h0);
        check("L_rst_cnt", 32'(bus.stall_cnt), 32'h0);
        rst = 1'b0;

        // sequential fetch
        step(1'b0, 1'b0, 32'h0);
        check("L_seq_pc", bus.pc_f, 32'h0000_3004);
        check("L_seq_ird", bus.ir_d, 32'h8C00_3000);
        check("L_seq_pc8d", bus.pc8_d, 32'h0000_3008);
        step(1'b0, 1'b0, 32'h0);
        check("L_seq_ire", bus.ir_e, 32'h8C00_3000);
        step(1'b0, 1'b0, 32'h0);
        check("L_seq_pc2", bus.pc_f, 32'h0000_300C);

        // two-cycle stall
        step(1'b1, 1'b0, 32'h0);
        check("L_st1_pc", bus.pc_f, 32'h0000_300C);
        check("L_st1_ird", bus.ir_d, 32'h8C00_3008);
        check("L_st1_ire", bus.ir_e, 32'h0);
        check("L_st1_rse", bus.rs_val_e, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("L_st2_pc", bus.pc_f, 32'h0000_300C);
        check("L_st2_cnt", 32'(bus.stall_cnt), 32'd2);
        step(1'b0, 1'b0, 32'h0);
        check("L_res_pc", bus.pc_f, 32'h0000_3010);
        check("L_res_ird", bus.ir_d, 32'h8C00_300C);

        // taken branch with delay slot
        step(1'b0, 1'b0, 32'h0);
        check("L_br_pcd", bus.pc_d, 32'h0000_3010);
        step(1'b0, 1'b1, 32'h0000_3040);
        check("L_br_pc", bus.pc_f, 32'h0000_3040);
        check("L_br_slot", bus.ir_d, 32'h8C00_3014);
        step(1'b0, 1'b0, 32'h0);
        check("L_br_tgt", bus.ir_d, 32'h8C00_3040);

        // redirect presented under stall
        step(1'b1, 1'b1, 32'h0000_3080);
        check("L_rs_hold", bus.pc_f, 32'h0000_3044);
        check("L_rs_cnt", 32'(bus.stall_cnt), 32'd3);
        step(1'b0, 1'b1, 32'h0000_3080);
        check("L_rs_pc", bus.pc_f, 32'h0000_3080);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);

        // reset during a stall
        rst = 1'b1;
        step(1'b1, 1'b1, 32'h0000_5000);
        check("L_mr_pc", bus.pc_f, 32'h0000_3000);
        check("L_mr_ird", bus.ir_d, 32'h0);
        check("L_mr_ire", bus.ir_e, 32'h0);
        check("L_mr_cnt", 32'(bus.stall_cnt), 32'h0);
        rst = 1'b0;

        // saturation on the 2-bit counter
        step(1'b1, 1'b0, 32'h0);
        check("L_sat1", 32'(bus2.stall_cnt), 32'd1);
        step(1'b1, 1'b0, 32'h0);
        check("L_sat2", 32'(bus2.stall_cnt), 32'd2);
        step(1'b1, 1'b0, 32'h0);
        check("L_sat3", 32'(bus2.stall_cnt), 32'd3);
        step(1'b1, 1'b0, 32'h0);
        check("L_sat4", 32'(bus2.stall_cnt), 32'd3);
        step(1'b1, 1'b0, 32'h0);
        check("L_sat5", 32'(bus2.stall_cnt), 32'd3);
        check("L_sat_wide", 32'(bus.stall_cnt), 32'd5);

        // PC and link wrap at the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        check("L_wr_pc", bus.pc_f, 32'hFFFF_FFF8);
        step(1'b0, 1'b0, 32'h0);
        check("L_wr_pc2", bus.pc_f, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        check("L_wr_pc3", bus.pc_f, 32'h0000_0000);
        check("L_wr_pc8d", bus.pc8_d, 32'h0000_0004);
        step(1'b0, 1'b0, 32'h0);
        check("L_wr_pc8e", bus.pc8_e, 32'h0000_0004);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
